// File: rtl/cp0_exc_pkg.sv
// Shared definitions for the CP0 exception/interrupt sequencer.
//   cp0_state_e  : sequencer states (RUN, SAVE, VEC, RET)
//   LVL_NONE     : cur_id value reported when no handler is active
//   VEC_BASE_DEF / VEC_SHIFT_DEF : default vector placement
package cp0_exc_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SAVE = 2'd1,
    ST_VEC  = 2'd2,
    ST_RET  = 2'd3
  } cp0_state_e;

  localparam logic [2:0]  LVL_NONE      = 3'd7;
  localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned VEC_SHIFT_DEF = 4;

endpackage

// File: rtl/cp0_exc_ctrl_prio.sv
// Lowest-index-wins priority encoder for interrupt requests.
// Ports:
//   i_req   : NIRQ-wide request vector (bit 0 highest priority)
//   o_valid : any request bit set
//   o_id    : index of the lowest set bit (0 when none)
module irq_prio_enc #(
  parameter int unsigned NIRQ = 3
) (
  input  logic [NIRQ-1:0] i_req,
  output logic            o_valid,
  output logic [2:0]      o_id
);

  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int unsigned k = 0; k < NIRQ; k++) begin
      if (i_req[k] && !o_valid) begin
        o_valid = 1'b1;
        o_id    = 3'(k);
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Interrupt/exception sequencer between the datapath PC logic and CP0.
// Latches interrupt requests, arbitrates by fixed priority, writes the
// return PC to EPC, redirects to a per-source vector, and returns to the
// EPC value on ERET.
// Configuration macro: CP0_NEST_EN
//   defined   : level stack NIRQ deep, IE kept on entry, preemption allowed
//   undefined : single-entry stack, entry clears IE, no preemption
// Ports:
//   clk, clr           : clock, synchronous active-high reset
//   irq_req            : interrupt request bits (set pending)
//   eint / dint        : set / clear global interrupt enable
//   inst_bound         : instruction boundary, takes only allowed here
//   pc_next            : return address captured on a take
//   eret               : ERET pulse
//   epc_rdata          : EPC value read from CP0
//   epc_we / epc_wdata : EPC write port to CP0
//   redirect / redirect_pc : PC override pulse and target
//   pending, ie, in_isr, cur_id : status outputs
module cp0_exc_ctrl
  import cp0_exc_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     NIRQ      = 3,
  parameter logic [WIDTH-1:0] VEC_BASE = WIDTH'(VEC_BASE_DEF),
  parameter int unsigned     VEC_SHIFT = VEC_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NIRQ-1:0]  irq_req,
  input  logic             eint,
  input  logic             dint,
  input  logic             inst_bound,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_rdata,
  output logic             epc_we,
  output logic [WIDTH-1:0] epc_wdata,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [NIRQ-1:0]  pending,
  output logic             ie,
  output logic             in_isr,
  output logic [2:0]       cur_id
);

`ifdef CP0_NEST_EN
  localparam int unsigned DEPTH = NIRQ;
`else
  localparam int unsigned DEPTH = 1;
`endif

  // Level is 4 bits so that "no handler" (NIRQ) stays distinct from id 7.
  localparam logic [3:0] LVL_IDLE = 4'(NIRQ);

  cp0_state_e       r_state, w_state_nxt;
  logic [NIRQ-1:0]  r_pending, w_clr_mask, w_mask_lvl, w_elig;
  logic             r_ie, w_ie_nxt;
  logic [3:0]       r_lvl, w_lvl_nxt, w_pop_lvl;
  logic [3:0]       r_sp, w_sp_nxt;
  logic [3:0]       r_stk [DEPTH];
  logic [2:0]       r_id;
  logic [WIDTH-1:0] r_epc_wdata;
  logic             r_epc_we, r_redirect, r_in_isr;
  logic [2:0]       r_cur_id;
  logic             w_take, w_push, w_pop, w_enc_valid;
  logic [2:0]       w_enc_id;
  logic [WIDTH-1:0] w_vec;

  always_comb begin
    for (int unsigned k = 0; k < NIRQ; k++) begin
      w_mask_lvl[k] = (4'(k) < r_lvl);
    end
  end

  assign w_elig = r_pending & {NIRQ{r_ie}} & w_mask_lvl;

  irq_prio_enc #(.NIRQ(NIRQ)) u_prio (
    .i_req   (w_elig),
    .o_valid (w_enc_valid),
    .o_id    (w_enc_id)
  );

  // Stack-full guard keeps a software re-enable inside a handler from
  // overrunning the single-entry stack of the non-nesting build.
  assign w_take = (r_state == ST_RUN) & inst_bound & ~eret & w_enc_valid &
                  (r_sp < 4'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (eret)        w_state_nxt = ST_RET;
        else if (w_take) w_state_nxt = ST_SAVE;
      end
      ST_SAVE: begin
        w_push      = 1'b1;
        w_state_nxt = ST_VEC;
      end
      ST_VEC:  w_state_nxt = ST_RUN;
      ST_RET: begin
        // Empty stack: redirect only, level stays idle.
        w_pop       = (r_sp != '0);
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_pop_lvl = LVL_IDLE;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (r_sp == 4'(k + 1)) w_pop_lvl = r_stk[k];
    end
  end

  always_comb begin
    w_lvl_nxt = r_lvl;
    w_sp_nxt  = r_sp;
    if (w_push) begin
      w_lvl_nxt = {1'b0, r_id};
      w_sp_nxt  = r_sp + 4'd1;
    end else if (w_pop) begin
      w_lvl_nxt = w_pop_lvl;
      w_sp_nxt  = r_sp - 4'd1;
    end
  end

  always_comb begin
    w_ie_nxt = r_ie;
    if (eint) w_ie_nxt = 1'b1;
    if (dint) w_ie_nxt = 1'b0;
`ifndef CP0_NEST_EN
    if (r_state == ST_SAVE) w_ie_nxt = 1'b0;
`endif
    if (r_state == ST_RET) w_ie_nxt = 1'b1;
  end

  assign w_clr_mask = (r_state == ST_SAVE) ? (NIRQ'(1) << r_id) : '0;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_RUN;
      r_pending   <= '0;
      r_ie        <= 1'b0;
      r_lvl       <= LVL_IDLE;
      r_sp        <= '0;
      r_id        <= '0;
      r_epc_wdata <= '0;
      r_epc_we    <= 1'b0;
      r_redirect  <= 1'b0;
      r_in_isr    <= 1'b0;
      r_cur_id    <= LVL_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= (r_pending & ~w_clr_mask) | irq_req;
      r_ie       <= w_ie_nxt;
      r_lvl      <= w_lvl_nxt;
      r_sp       <= w_sp_nxt;
      r_in_isr   <= (w_sp_nxt != '0);
      r_cur_id   <= (w_lvl_nxt >= LVL_IDLE) ? LVL_NONE : w_lvl_nxt[2:0];
      r_epc_we   <= (w_state_nxt == ST_SAVE);
      r_redirect <= (w_state_nxt == ST_VEC) || (w_state_nxt == ST_RET);
      if (w_take) begin
        r_id        <= w_enc_id;
        r_epc_wdata <= pc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_push && (r_sp == 4'(k))) r_stk[k] <= r_lvl;
    end
  end

  assign w_vec       = VEC_BASE + (WIDTH'(r_id) << VEC_SHIFT);
  assign redirect_pc = !r_redirect ? '0 :
                       (r_state == ST_RET) ? epc_rdata : w_vec;

  assign epc_we    = r_epc_we;
  assign epc_wdata = r_epc_wdata;
  assign redirect  = r_redirect;
  assign pending   = r_pending;
  assign ie        = r_ie;
  assign in_isr    = r_in_isr;
  assign cur_id    = r_cur_id;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        clr, eint, dint, inst_bound, eret;
  logic [2:0]  irq_req;
  logic [31:0] pc_next, epc_rdata;
  logic        epc_we, redirect, ie, in_isr;
  logic [31:0] epc_wdata, redirect_pc;
  logic [2:0]  pending, cur_id;

  int checks   = 0;
  int failures = 0;

  cp0_exc_ctrl #(
    .WIDTH    (32),
    .NIRQ     (3),
    .VEC_BASE (32'h0000_3000),
    .VEC_SHIFT(4)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .irq_req    (irq_req),
    .eint       (eint),
    .dint       (dint),
    .inst_bound (inst_bound),
    .pc_next    (pc_next),
    .eret       (eret),
    .epc_rdata  (epc_rdata),
    .epc_we     (epc_we),
    .epc_wdata  (epc_wdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pending    (pending),
    .ie         (ie),
    .in_isr     (in_isr),
    .cur_id     (cur_id)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs driven 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; eint = 1'b0; dint = 1'b0; inst_bound = 1'b0; eret = 1'b0;
    irq_req = '0; pc_next = '0; epc_rdata = '0;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending !== 3'b000) begin failures++; $display("FAIL reset_pending got=%b exp=000", pending); end
    checks++; if (ie !== 1'b0) begin failures++; $display("FAIL reset_ie got=%b exp=0", ie); end
    checks++; if (epc_we !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL reset_pulses got we=%b rd=%b exp=0,0", epc_we, redirect); end
    checks++; if (epc_wdata !== 32'h0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_data got wd=%h rpc=%h exp=0,0", epc_wdata, redirect_pc); end
    checks++; if (in_isr !== 1'b0 || cur_id !== 3'd7) begin failures++; $display("FAIL reset_isr got in_isr=%b cur_id=%0d exp=0,7", in_isr, cur_id); end
  endtask

  task automatic test_single_irq();
    do_reset();
    eint = 1'b1; step(); eint = 1'b0;
    irq_req = 3'b100; inst_bound = 1'b1; pc_next = 32'h100;
    step();
    irq_req = '0;
    checks++; if (pending !== 3'b100 || epc_we !== 1'b0) begin failures++; $display("FAIL single_pend got pend=%b we=%b exp=100,0", pending, epc_we); end
    step();
    checks++; if (epc_we !== 1'b1 || epc_wdata !== 32'h100 || redirect !== 1'b0) begin failures++; $display("FAIL single_save got we=%b wd=%h rd=%b exp=1,100,0", epc_we, epc_wdata, redirect); end
    step();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h3020 || epc_we !== 1'b0) begin failures++; $display("FAIL single_vec got rd=%b rpc=%h we=%b exp=1,3020,0", redirect, redirect_pc, epc_we); end
    checks++; if (pending !== 3'b000 || cur_id !== 3'd2 || in_isr !== 1'b1) begin failures++; $display("FAIL single_state got pend=%b cur=%0d isr=%b exp=000,2,1", pending, cur_id, in_isr); end
`ifndef CP0_NEST_EN
    checks++; if (ie !== 1'b0) begin failures++; $display("FAIL single_ie_clr got=%b exp=0", ie); end
`endif
    step();
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL single_rd_pulse got=%b exp=0", redirect); end
  endtask

  // Runs directly after test_single_irq, inside the id 2 handler.
  task automatic test_eret();
    epc_rdata = 32'h100; eret = 1'b1;
    step();
    eret = 1'b0;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin failures++; $display("FAIL eret_redirect got rd=%b rpc=%h exp=1,100", redirect, redirect_pc); end
    step();
    checks++; if (ie !== 1'b1 || cur_id !== 3'd7 || in_isr !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL eret_state got ie=%b cur=%0d isr=%b rd=%b exp=1,7,0,0", ie, cur_id, in_isr, redirect); end
    epc_rdata = 32'h200; eret = 1'b1;
    step();
    eret = 1'b0;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin failures++; $display("FAIL eret_empty_rd got rd=%b rpc=%h exp=1,200", redirect, redirect_pc); end
    step();
    checks++; if (cur_id !== 3'd7 || in_isr !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL eret_empty_state got cur=%0d isr=%b rd=%b exp=7,0,0", cur_id, in_isr, redirect); end
  endtask

  task automatic test_priority();
    do_reset();
    eint = 1'b1; step(); eint = 1'b0;
    irq_req = 3'b110; inst_bound = 1'b1; pc_next = 32'h240;
    step();
    irq_req = '0;
    checks++; if (pending !== 3'b110) begin failures++; $display("FAIL prio_pend got=%b exp=110", pending); end
    step();
    checks++; if (epc_we !== 1'b1 || epc_wdata !== 32'h240) begin failures++; $display("FAIL prio_save got we=%b wd=%h exp=1,240", epc_we, epc_wdata); end
    step();
    checks++; if (redirect_pc !== 32'h3010 || pending !== 3'b100 || cur_id !== 3'd1) begin failures++; $display("FAIL prio_vec got rpc=%h pend=%b cur=%0d exp=3010,100,1", redirect_pc, pending, cur_id); end
    step();
    checks++; if (epc_we !== 1'b0 || pending !== 3'b100) begin failures++; $display("FAIL prio_hold got we=%b pend=%b exp=0,100", epc_we, pending); end
    epc_rdata = 32'h44; eret = 1'b1;
    step();
    eret = 1'b0;
    checks++; if (redirect_pc !== 32'h44) begin failures++; $display("FAIL prio_eret got=%h exp=44", redirect_pc); end
    step();
    step();
    checks++; if (epc_we !== 1'b1) begin failures++; $display("FAIL prio_second_save got=%b exp=1", epc_we); end
    step();
    checks++; if (redirect_pc !== 32'h3020 || pending !== 3'b000) begin failures++; $display("FAIL prio_second_vec got rpc=%h pend=%b exp=3020,000", redirect_pc, pending); end
  endtask

  task automatic test_defer_ie();
    int seen_we;
    do_reset();
    eint = 1'b1; step(); eint = 1'b0;
    irq_req = 3'b001; inst_bound = 1'b0; pc_next = 32'h300;
    step();
    irq_req = '0;
    seen_we = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (epc_we !== 1'b0) seen_we++;
    end
    checks++; if (seen_we != 0 || pending !== 3'b001) begin failures++; $display("FAIL defer_hold got we_cycles=%0d pend=%b exp=0,001", seen_we, pending); end
    inst_bound = 1'b1;
    step();
    checks++; if (epc_we !== 1'b1 || epc_wdata !== 32'h300) begin failures++; $display("FAIL defer_take got we=%b wd=%h exp=1,300", epc_we, epc_wdata); end
    step();
    checks++; if (redirect_pc !== 32'h3000 || cur_id !== 3'd0) begin failures++; $display("FAIL defer_vec got rpc=%h cur=%0d exp=3000,0", redirect_pc, cur_id); end

    do_reset();
    eint = 1'b1; dint = 1'b1; irq_req = 3'b001; inst_bound = 1'b1;
    step();
    eint = 1'b0; dint = 1'b0; irq_req = '0;
    checks++; if (ie !== 1'b0) begin failures++; $display("FAIL ie_both got=%b exp=0", ie); end
    seen_we = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (epc_we !== 1'b0) seen_we++;
    end
    checks++; if (seen_we != 0 || pending !== 3'b001) begin failures++; $display("FAIL ie_both_notake got we_cycles=%0d pend=%b exp=0,001", seen_we, pending); end
  endtask

  task automatic test_nesting();
    int seen_we;
    do_reset();
    eint = 1'b1; step(); eint = 1'b0;
    irq_req = 3'b100; inst_bound = 1'b1; pc_next = 32'h500;
    step();
    irq_req = '0;
    step();
    step();
    checks++; if (cur_id !== 3'd2 || redirect_pc !== 32'h3020) begin failures++; $display("FAIL nest_enter got cur=%0d rpc=%h exp=2,3020", cur_id, redirect_pc); end
    irq_req = 3'b001; pc_next = 32'h600;
    step();
    irq_req = '0;
`ifdef CP0_NEST_EN
    step();
    checks++; if (epc_we !== 1'b1 || epc_wdata !== 32'h600) begin failures++; $display("FAIL nest_preempt_save got we=%b wd=%h exp=1,600", epc_we, epc_wdata); end
    step();
    checks++; if (redirect_pc !== 32'h3000 || cur_id !== 3'd0) begin failures++; $display("FAIL nest_preempt_vec got rpc=%h cur=%0d exp=3000,0", redirect_pc, cur_id); end
    irq_req = 3'b100;
    step();
    irq_req = '0;
    seen_we = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (epc_we !== 1'b0) seen_we++;
    end
    checks++; if (seen_we != 0 || pending !== 3'b100) begin failures++; $display("FAIL nest_mask got we_cycles=%0d pend=%b exp=0,100", seen_we, pending); end
    eret = 1'b1; step(); eret = 1'b0;
    step();
    checks++; if (cur_id !== 3'd2 || epc_we !== 1'b0) begin failures++; $display("FAIL nest_pop got cur=%0d we=%b exp=2,0", cur_id, epc_we); end
    eret = 1'b1; step(); eret = 1'b0;
    step();
    step();
    checks++; if (epc_we !== 1'b1) begin failures++; $display("FAIL nest_retake got=%b exp=1", epc_we); end
`else
    seen_we = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (epc_we !== 1'b0) seen_we++;
    end
    checks++; if (seen_we != 0 || pending !== 3'b001 || cur_id !== 3'd2) begin failures++; $display("FAIL nest_wait got we_cycles=%0d pend=%b cur=%0d exp=0,001,2", seen_we, pending, cur_id); end
    epc_rdata = 32'h500; eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    step();
    checks++; if (epc_we !== 1'b1 || epc_wdata !== 32'h600) begin failures++; $display("FAIL nest_after_eret_save got we=%b wd=%h exp=1,600", epc_we, epc_wdata); end
    step();
    checks++; if (redirect_pc !== 32'h3000 || cur_id !== 3'd0) begin failures++; $display("FAIL nest_after_eret_vec got rpc=%h cur=%0d exp=3000,0", redirect_pc, cur_id); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    eint = 1'b1; step(); eint = 1'b0;
    irq_req = 3'b010; inst_bound = 1'b1; pc_next = 32'h700;
    step();
    irq_req = '0;
    step();
    checks++; if (epc_we !== 1'b1) begin failures++; $display("FAIL mid_in_save got=%b exp=1", epc_we); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (redirect !== 1'b0 || epc_we !== 1'b0 || pending !== 3'b000 || ie !== 1'b0) begin failures++; $display("FAIL mid_clr got rd=%b we=%b pend=%b ie=%b exp=0,0,000,0", redirect, epc_we, pending, ie); end
    checks++; if (cur_id !== 3'd7 || in_isr !== 1'b0) begin failures++; $display("FAIL mid_clr_isr got cur=%0d isr=%b exp=7,0", cur_id, in_isr); end
    step();
    checks++; if (redirect !== 1'b0 || epc_we !== 1'b0) begin failures++; $display("FAIL mid_after got rd=%b we=%b exp=0,0", redirect, epc_we); end
  endtask

  initial begin
    test_reset();
    test_single_irq();
    test_eret();
    test_priority();
    test_defer_ie();
    test_nesting();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
